// File: rtl/psum_ofifo_pkg.sv
// Shared defaults for the psum output collector and the pointer-width helper.
package psum_ofifo_pkg;

   localparam int PSUM_BW_DEF = 16;
   localparam int COL_DEF     = 8;
   localparam int DEPTH_DEF   = 64;

   // One extra MSB beyond the address distinguishes full from empty.
   function automatic int ptr_w(input int d);
      return $clog2(d) + 1;
   endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// One column lane: show-ahead FIFO with an extended-pointer full/empty scheme and a sticky drop flag.
module psum_col_fifo
   import psum_ofifo_pkg::*;
#(
   parameter int psum_bw = PSUM_BW_DEF,
   parameter int depth   = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic               rd,
   input  logic [psum_bw-1:0] in,
   output logic [psum_bw-1:0] out,
   output logic               empty,
   output logic               full,
   output logic               overflow
);

   localparam int PW = ptr_w(depth);
   localparam int AW = PW - 1;

   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [psum_bw-1:0] mem [depth];
   logic               wr_ok;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // rd is only ever a row pop, so a full lane frees its head slot in the same edge.
   assign wr_ok = wr & (~full | rd);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (rd)    rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         if (wr & ~wr_ok) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_ok) mem[wr_ptr[AW-1:0]] <= in;
   end

   assign out = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/psum_ofifo.sv
// Re-aligns skewed per-column psums into full rows; a row pops from all lanes at once.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int psum_bw = PSUM_BW_DEF,
   parameter int col     = COL_DEF,
   parameter int depth   = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_overflow
);

   logic [col-1:0]              empty, full, ovf;
   logic [col-1:0][psum_bw-1:0] lane_out;
   logic                        pop;

   assign pop = rd & o_valid;

   for (genvar c = 0; c < col; c++) begin : g_lane
      psum_col_fifo #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .wr       (wr[c]),
         .rd       (pop),
         .in       (in[psum_bw*c +: psum_bw]),
         .out      (lane_out[c]),
         .empty    (empty[c]),
         .full     (full[c]),
         .overflow (ovf[c])
      );
   end

   assign o_valid    = ~|empty;
   assign o_full     = |full;
   assign o_ready    = ~o_full;
   assign o_overflow = |ovf;
   assign out        = o_valid ? lane_out : '0;

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized and directed checks of psum_ofifo against a per-lane queue model.
module tb_psum_ofifo;

   localparam int BW = 16;
   localparam int NC = 8;
   localparam int DP = 64;
   localparam int W  = BW * NC;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  in;
   logic [NC-1:0] wr;
   logic          rd;
   logic [W-1:0]  out;
   logic          o_valid, o_full, o_ready, o_overflow;

   int vectors = 0;
   int miscompares = 0;

   logic [BW-1:0] q [NC][$];
   bit            m_ovf;

   always #5 clk = ~clk;

   psum_ofifo #(.psum_bw(BW), .col(NC), .depth(DP)) dut (
      .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
      .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
   );

   function automatic bit m_valid();
      for (int c = 0; c < NC; c++) if (q[c].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_full();
      for (int c = 0; c < NC; c++) if (q[c].size() == DP) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] m_out();
      logic [W-1:0] r;
      r = '0;
      if (m_valid())
         for (int c = 0; c < NC; c++) r[BW*c +: BW] = q[c][0];
      return r;
   endfunction

   function automatic logic [W-1:0] row_of(input int base, input int stride);
      logic [W-1:0] r;
      for (int c = 0; c < NC; c++) r[BW*c +: BW] = 16'(base + c * stride);
      return r;
   endfunction

   // Apply one clock of stimulus, advance the model, then settle past the edge.
   task automatic tick(input logic [NC-1:0] w, input logic [W-1:0] d, input logic r, input logic rs);
      bit pop;
      pop = r && m_valid();
      reset = rs; wr = w; in = d; rd = r;
      @(posedge clk);
      if (!rs) begin
         for (int c = 0; c < NC; c++) q[c].delete();
         m_ovf = 1'b0;
      end else begin
         for (int c = 0; c < NC; c++) begin
            bit was_full;
            was_full = (q[c].size() == DP);
            if (pop) void'(q[c].pop_front());
            if (w[c]) begin
               if (!was_full || pop) q[c].push_back(d[BW*c +: BW]);
               else m_ovf = 1'b1;
            end
         end
      end
      #1;
      wr = '0; rd = 1'b0;
   endtask

   task automatic do_reset();
      tick('0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      tick(8'hFF, {4{32'($urandom)}}, 1'b0, 1'b0);
      tick(8'hFF, {4{32'($urandom)}}, 1'b1, 1'b0);
      vectors++;
      if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      vectors++;
      if (o_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", o_full); end
      vectors++;
      if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
      vectors++;
      if (o_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", o_overflow); end
      vectors++;
      if (out !== '0) begin miscompares++; $display("FAIL reset_out got=%h exp=0", out); end
   endtask

   task automatic test_skew();
      logic [W-1:0] exp_row;
      do_reset();
      exp_row = row_of(16'h0100, 1);
      for (int c = 0; c < NC; c++) begin
         logic [W-1:0] d;
         d = '0;
         d[BW*c +: BW] = 16'(16'h0100 + c);
         tick(NC'(1) << c, d, 1'b0, 1'b1);
         vectors++;
         if (o_valid !== (c == NC - 1)) begin
            miscompares++; $display("FAIL skew_valid lane=%0d got=%b exp=%b", c, o_valid, c == NC - 1);
         end
      end
      vectors++;
      if (out !== exp_row) begin miscompares++; $display("FAIL skew_out got=%h exp=%h", out, exp_row); end
      tick('0, '0, 1'b1, 1'b1);
      vectors++;
      if (o_valid !== 1'b0) begin miscompares++; $display("FAIL skew_pop_valid got=%b exp=0", o_valid); end
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int i = 0; i < DP; i++) begin
         tick(8'hFF, row_of(i, 0), 1'b0, 1'b1);
         vectors++;
         if (o_full !== (i == DP - 1)) begin
            miscompares++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, o_full, i == DP - 1);
         end
      end
      vectors++;
      if (o_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got=%b exp=0", o_ready); end
      tick(8'h08, row_of(16'hDEAD, 0), 1'b0, 1'b1);
      vectors++;
      if (o_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", o_overflow); end
      for (int i = 0; i < DP; i++) begin
         vectors++;
         if (out !== row_of(i, 0)) begin
            miscompares++; $display("FAIL ovf_readback i=%0d got=%h exp=%h", i, out, row_of(i, 0));
         end
         tick('0, '0, 1'b1, 1'b1);
      end
      vectors++;
      if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin
         miscompares++; $display("FAIL ovf_drained valid=%b ovf=%b exp valid=0 ovf=1", o_valid, o_overflow);
      end
   endtask

   task automatic test_full_pop();
      logic [W-1:0] nrow;
      do_reset();
      for (int i = 0; i < DP; i++) tick(8'hFF, row_of(i, 0), 1'b0, 1'b1);
      nrow = row_of(16'hA500, 3);
      tick(8'hFF, nrow, 1'b1, 1'b1);
      vectors++;
      if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
         miscompares++; $display("FAIL fullpop_flags full=%b ovf=%b exp full=1 ovf=0", o_full, o_overflow);
      end
      for (int i = 1; i < DP; i++) begin
         vectors++;
         if (out !== row_of(i, 0)) begin
            miscompares++; $display("FAIL fullpop_row i=%0d got=%h exp=%h", i, out, row_of(i, 0));
         end
         tick('0, '0, 1'b1, 1'b1);
      end
      vectors++;
      if (out !== nrow) begin miscompares++; $display("FAIL fullpop_last got=%h exp=%h", out, nrow); end
      tick('0, '0, 1'b1, 1'b1);
   endtask

   task automatic test_wrap();
      int widx, ridx;
      do_reset();
      widx = 0; ridx = 0;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 40; i++) begin
            tick(8'hFF, row_of(widx, 1000), 1'b0, 1'b1);
            widx++;
         end
         for (int i = 0; i < 40; i++) begin
            vectors++;
            if (out !== row_of(ridx, 1000)) begin
               miscompares++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", ridx, out, row_of(ridx, 1000));
            end
            tick('0, '0, 1'b1, 1'b1);
            ridx++;
            vectors++;
            if (o_valid !== (i != 39)) begin
               miscompares++; $display("FAIL wrap_valid idx=%0d got=%b exp=%b", ridx, o_valid, i != 39);
            end
         end
      end
   endtask

   task automatic test_midreset();
      logic [W-1:0] row;
      do_reset();
      for (int i = 0; i < 10; i++) tick(8'hFF, row_of(i + 50, 7), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick('0, '0, 1'b1, 1'b1);
      tick('0, '0, 1'b1, 1'b0);
      vectors++;
      if (o_valid !== 1'b0 || out !== '0) begin
         miscompares++; $display("FAIL midreset_clear valid=%b out=%h exp valid=0 out=0", o_valid, out);
      end
      row = {4{32'($urandom)}};
      tick(8'hFF, row, 1'b0, 1'b1);
      vectors++;
      if (o_valid !== 1'b1 || out !== row) begin
         miscompares++; $display("FAIL midreset_row valid=%b got=%h exp=%h", o_valid, out, row);
      end
      tick('0, '0, 1'b1, 1'b1);
      vectors++;
      if (o_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_only got=%b exp=0", o_valid); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         logic [NC-1:0] w;
         logic          r, rs;
         w  = NC'($urandom);
         // Slow reader in the first half drives lanes into full; fast reader drains later.
         r  = ($urandom_range(0, 99) < ((n < 750) ? 15 : 85));
         rs = ($urandom_range(0, 299) != 0);
         tick(w, {4{32'($urandom)}}, r, rs);
         vectors++;
         if (o_valid !== m_valid() || o_full !== m_full() || o_ready !== !m_full() || o_overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL rand_flags n=%0d got v=%b f=%b r=%b o=%b exp v=%b f=%b r=%b o=%b", n,
                     o_valid, o_full, o_ready, o_overflow, m_valid(), m_full(), !m_full(), m_ovf);
         end
         vectors++;
         if (out !== m_out()) begin
            miscompares++; $display("FAIL rand_out n=%0d got=%h exp=%h", n, out, m_out());
         end
      end
   endtask

   initial begin
      reset = 1'b0; wr = '0; rd = 1'b0; in = '0; m_ovf = 1'b0;
      test_reset();
      test_skew();
      test_full_overflow();
      test_full_pop();
      test_wrap();
      test_midreset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
